// File: rtl/gps_sig_gen_pkg.sv
// Shared GPS definitions: register-write op bits, L1 C/A code constants and
// the Gold-code shift-register taps used by the signal generator.
package gps_sig_gen_pkg;

  localparam int L1_CODELEN = 1023;

  // Channel op bits occupy 0..9; generator ops are allocated after them.
  localparam int SET_GEN_SAT  = 10;
  localparam int SET_GEN_LO   = 11;
  localparam int SET_GEN_CG   = 12;
  localparam int SET_GEN_DATA = 13;
  localparam int SET_GEN_CTRL = 14;

  localparam logic [15:0] GEN_OP_MASK = 16'b0111_1100_0000_0000;

  // Stage n of a tap vector is bit n (stages numbered 1..10).
  localparam logic [10:1] G1_TAPS = 10'b10_0000_0100;  // 1 + x^3 + x^10
  localparam logic [10:1] G2_TAPS = 10'b11_1010_0110;  // 1 + x^2+x^3+x^6+x^8+x^9+x^10

  typedef enum logic {
    GEN_IDLE = 1'b0,
    GEN_RUN  = 1'b1
  } gen_state_t;

  // Shift toward stage 10, feedback (XOR of tapped stages) enters stage 1.
  function automatic logic [10:1] lfsr_step(input logic [10:1] r, input logic [10:1] taps);
    lfsr_step = {r[9:1], ^(r & taps)};
  endfunction

endpackage

// File: rtl/ca_gen_lfsr.sv
// G1/G2 Gold-code pair for the C/A generator. `chip` reflects the state being
// written at this edge, so the parent can register it alongside its own next-state terms.
module ca_gen_lfsr
  import gps_sig_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [10:1] g2_init,
  output logic        chip
);

  logic [10:1] g1;
  logic [10:1] g2;
  logic [10:1] g1_next;
  logic [10:1] g2_next;

  always_comb begin
    g1_next = g1;
    g2_next = g2;
    if (load) begin
      g1_next = '1;
      g2_next = g2_init;
    end else if (adv) begin
      g1_next = lfsr_step(g1, G1_TAPS);
      g2_next = lfsr_step(g2, G2_TAPS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '1;
      g2 <= '0;
    end else begin
      g1 <= g1_next;
      g2 <= g2_next;
    end
  end

  assign chip = g1_next[10] ^ g2_next[10];

endmodule

// File: rtl/gps_sig_gen.sv
// Synthetic GPS L1 C/A sign-sample generator: code NCO, carrier NCO, Gold code
// and 50 bps nav data, programmed through the channel register-write bus.
module gps_sig_gen
  import gps_sig_gen_pkg::*;
#(
  parameter int CODELEN        = L1_CODELEN,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrReg,
  input  logic [15:0] op,
  input  logic [31:0] tos,
  output logic        sample,
  output logic        epoch,
  output logic        data_req,
  output logic        running
);

  localparam int CW = $clog2(CODELEN);
  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CHIP  = CW'(CODELEN - 1);
  localparam logic [EW-1:0] LAST_EPOCH = EW'(EPOCHS_PER_BIT - 1);

  gen_state_t    state;
  logic [31:0]   lo_rate;
  logic [31:0]   cg_rate;
  logic [31:0]   lo_phase;
  logic [31:0]   cg_phase;
  logic [31:0]   data_word;
  logic [10:1]   g2_init;
  logic [CW-1:0] chip_idx;
  logic [EW-1:0] epoch_cnt;
  logic [4:0]    bit_idx;

  logic [31:0]   lo_next;
  logic [31:0]   cg_next;
  logic [31:0]   data_word_next;
  logic [CW-1:0] chip_idx_next;
  logic [EW-1:0] epoch_cnt_next;
  logic [4:0]    bit_idx_next;
  logic          data_req_next;
  logic          chip_adv;
  logic          code_wrap;
  logic          bit_adv;
  logic          dbit_next;
  logic          chip_next;
  logic          active_next;

  logic wr_sat, wr_lo, wr_cg, wr_data, wr_ctrl, start, stop;
  logic unused_op;

  assign wr_sat   = wrReg & op[SET_GEN_SAT];
  assign wr_lo    = wrReg & op[SET_GEN_LO];
  assign wr_cg    = wrReg & op[SET_GEN_CG];
  assign wr_data  = wrReg & op[SET_GEN_DATA];
  assign wr_ctrl  = wrReg & op[SET_GEN_CTRL];
  assign start    = wr_ctrl & tos[0];
  assign stop     = wr_ctrl & ~tos[0];
  assign unused_op = ^(op & ~GEN_OP_MASK);

  assign active_next = start | ((state == GEN_RUN) & ~stop);

  // Everything is computed as next state so that `sample` in a cycle reflects
  // the NCO/code/data state held in that same cycle, starting at phase 0.
  always_comb begin
    lo_next        = lo_phase;
    cg_next        = cg_phase;
    chip_adv       = 1'b0;
    code_wrap      = 1'b0;
    bit_adv        = 1'b0;
    chip_idx_next  = chip_idx;
    epoch_cnt_next = epoch_cnt;
    bit_idx_next   = bit_idx;
    data_req_next  = data_req;
    if (start) begin
      lo_next        = '0;
      cg_next        = '0;
      chip_idx_next  = '0;
      epoch_cnt_next = '0;
    end else if (state == GEN_RUN && !stop) begin
      lo_next = lo_phase + lo_rate;
      {chip_adv, cg_next} = {1'b0, cg_phase} + {1'b0, cg_rate};
      if (chip_adv) begin
        if (chip_idx == LAST_CHIP) begin
          code_wrap     = 1'b1;
          chip_idx_next = '0;
          if (epoch_cnt == LAST_EPOCH) begin
            epoch_cnt_next = '0;
            bit_adv        = 1'b1;
          end else begin
            epoch_cnt_next = epoch_cnt + 1'b1;
          end
        end else begin
          chip_idx_next = chip_idx + 1'b1;
        end
      end
    end
    if (bit_adv && !data_req) begin
      if (bit_idx == 5'd31) data_req_next = 1'b1;
      bit_idx_next = bit_idx + 5'd1;
    end
    // A reload landing on a bit boundary restarts at bit 0 of the new word.
    if (wr_data) begin
      bit_idx_next  = '0;
      data_req_next = 1'b0;
    end
  end

  assign data_word_next = wr_data ? tos : data_word;
  assign dbit_next      = data_req_next ? 1'b0 : data_word_next[5'd31 - bit_idx_next];

  ca_gen_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start | code_wrap),
    .adv     (chip_adv),
    .g2_init (g2_init),
    .chip    (chip_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_rate   <= '0;
      cg_rate   <= '0;
      g2_init   <= '0;
      data_word <= '0;
      bit_idx   <= '0;
      data_req  <= 1'b1;
      lo_phase  <= '0;
      cg_phase  <= '0;
      chip_idx  <= '0;
      epoch_cnt <= '0;
    end else begin
      if (wr_sat) g2_init <= tos[9:0];
      if (wr_lo)  lo_rate <= tos;
      if (wr_cg)  cg_rate <= tos;
      data_word <= data_word_next;
      bit_idx   <= bit_idx_next;
      data_req  <= data_req_next;
      lo_phase  <= lo_next;
      cg_phase  <= cg_next;
      chip_idx  <= chip_idx_next;
      epoch_cnt <= epoch_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= GEN_IDLE;
      running <= 1'b0;
      sample  <= 1'b0;
      epoch   <= 1'b0;
    end else begin
      case (state)
        GEN_IDLE: if (start) state <= GEN_RUN;
        GEN_RUN:  if (stop)  state <= GEN_IDLE;
      endcase
      running <= active_next;
      sample  <= active_next & (lo_next[31] ^ chip_next ^ dbit_next);
      epoch   <= start | code_wrap;
    end
  end

endmodule

// File: tb/tb_gps_sig_gen.sv
// Randomized bench for gps_sig_gen against a closed-form model: Gold code from
// its output-stream recurrences, NCOs as plain modular sums, data bit from epoch count.
module tb_gps_sig_gen;
  import gps_sig_gen_pkg::*;

  localparam int CL  = 1023;
  localparam int EPB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrReg;
  logic [15:0] op;
  logic [31:0] tos;
  logic        sample, epoch, data_req, running;

  int n_checks = 0;
  int n_fail   = 0;

  gps_sig_gen #(.CODELEN(CL), .EPOCHS_PER_BIT(EPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .wrReg    (wrReg),
    .op       (op),
    .tos      (tos),
    .sample   (sample),
    .epoch    (epoch),
    .data_req (data_req),
    .running  (running)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          g1s [CL+10];
  bit          g2s [CL+10];
  bit          ca  [CL];
  int unsigned m_lo, m_cg, m_lo_rate, m_cg_rate;
  longint      m_n, m_k, m_k_prev, m_epoch_base;
  logic [31:0] m_word;
  bit          samp_log [64];

  task automatic build_code(input logic [9:0] init);
    for (int i = 0; i < 10; i++) begin
      g1s[i] = 1'b1;
      g2s[i] = init[9-i];
    end
    for (int i = 0; i < CL; i++) begin
      g1s[i+10] = g1s[i+7] ^ g1s[i];
      g2s[i+10] = g2s[i+8] ^ g2s[i+7] ^ g2s[i+4] ^ g2s[i+2] ^ g2s[i+1] ^ g2s[i];
    end
    for (int i = 0; i < CL; i++) ca[i] = g1s[i] ^ g2s[i];
  endtask

  // Expected {sample, epoch, running, data_req} for model cycle m_n.
  task automatic model_expect(output logic [3:0] e);
    longint ep, bn;
    logic   d;
    ep = m_k / CL;
    bn = (ep - m_epoch_base) / EPB;
    d  = 1'b0;
    if (bn < 32) d = m_word[31 - int'(bn)];
    e[3] = m_lo[31] ^ ca[int'(m_k % CL)] ^ d;
    e[2] = (m_n == 0) || (m_k != m_k_prev && (m_k % CL) == 0);
    e[1] = 1'b1;
    e[0] = (bn >= 32);
  endtask

  task automatic model_advance();
    longint unsigned s;
    m_k_prev = m_k;
    m_lo     = m_lo + m_lo_rate;
    s        = longint'(m_cg) + longint'(m_cg_rate);
    m_k      = m_k + longint'(s >> 32);
    m_cg     = 32'(s);
    m_n++;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    wrReg = 1'b1;
    op = '0;
    op[idx] = 1'b1;
    tos = d;
    @(posedge clk);
    #1;
    wrReg = 1'b0;
    op = '0;
  endtask

  task automatic start_gen(input logic [9:0] g2, input logic [31:0] lo, input logic [31:0] cg,
                           input logic [31:0] word);
    wr(SET_GEN_SAT, {22'd0, g2});
    wr(SET_GEN_LO, lo);
    wr(SET_GEN_CG, cg);
    wr(SET_GEN_DATA, word);
    build_code(g2);
    m_n = 0; m_lo = 0; m_cg = 0; m_k = 0; m_k_prev = 0; m_epoch_base = 0;
    m_lo_rate = lo; m_cg_rate = cg; m_word = word;
    wr(SET_GEN_CTRL, 32'd1);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({sample, epoch, running, data_req} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_values got %b expected 0001 (sample,epoch,running,data_req)",
               {sample, epoch, running, data_req});
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sample, epoch, running, data_req} !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got %b expected 0001", c, {sample, epoch, running, data_req});
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_prn1();
    logic [3:0]  e;
    logic [9:0]  prefix;
    int          lf = 0;
    longint      ep_q[$];
    prefix = 10'b1100100000;
    start_gen(10'b0011011111, 32'd0, 32'h8000_0000, 32'd0);
    for (int c = 0; c < 2 * 2046 + 20; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL prn1 n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      if (m_n < 64) samp_log[m_n] = sample;
      if (epoch === 1'b1) ep_q.push_back(m_n);
      model_advance();
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (samp_log[i] !== prefix[9 - i/2]) begin
        n_fail++;
        $display("FAIL prn1_prefix cycle=%0d got %b expected %b", i, samp_log[i], prefix[9 - i/2]);
      end
    end
    n_checks++;
    if (ep_q.size() != 3 || ep_q[0] != 0 || ep_q[1] != 2046 || ep_q[2] != 4092) begin
      n_fail++;
      $display("FAIL prn1_epochs got %p expected '{0,2046,4092}", ep_q);
    end
    $display("test_prn1: %0d cycles", m_n);
  endtask

  task automatic test_carrier();
    logic [3:0] e;
    int         lf = 0;
    start_gen(10'($urandom_range(1023, 1)), 32'h4000_0000, 32'd0, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL carrier n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      model_advance();
    end
    $display("test_carrier: %0d cycles", m_n);
  endtask

  task automatic test_data();
    logic [3:0] e;
    int         lf = 0;
    start_gen(10'b0011011111, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000);
    for (int c = 0; c < 64 * CL + 30; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL data n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      model_advance();
    end
    n_checks++;
    if (data_req !== 1'b1) begin
      n_fail++;
      $display("FAIL data_req_end got %b expected 1", data_req);
    end
    $display("test_data: %0d cycles", m_n);
  endtask

  task automatic test_race();
    logic [3:0]  e;
    logic [31:0] w1, w2;
    bit          armed = 1'b1;
    bit          clear_wr = 1'b0;
    int          lf = 0;
    w1 = $urandom;
    w2 = $urandom;
    w2[31] = ~w1[30];
    w2[30] = w1[30];
    start_gen(10'($urandom_range(1023, 1)), $urandom, 32'hFFFF_FFFF, w1);
    for (int c = 0; c < 4 * CL + 40; c++) begin
      @(negedge clk);
      if (clear_wr) begin
        wrReg = 1'b0; op = '0; clear_wr = 1'b0;
      end
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL race n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      model_advance();
      // The next edge crosses into data bit 1: land the reload on that same edge.
      if (armed && (m_k / CL) == EPB && (m_k_prev / CL) < EPB) begin
        wrReg = 1'b1; op = '0; op[SET_GEN_DATA] = 1'b1; tos = w2;
        m_word = w2; m_epoch_base = EPB; armed = 1'b0; clear_wr = 1'b1;
      end
    end
    wrReg = 1'b0; op = '0;
    n_checks++;
    if (armed) begin
      n_fail++;
      $display("FAIL race_reached got armed=%0b expected 0", armed);
    end
    $display("test_race: %0d cycles", m_n);
  endtask

  task automatic test_stop_restart();
    logic [3:0] e;
    logic [9:0] prefix;
    int         lf = 0;
    prefix = 10'b1100100000;
    start_gen(10'b0011011111, $urandom, 32'h8000_0000, 32'd0);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL stop_pre n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      model_advance();
    end
    wr(SET_GEN_CTRL, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sample, epoch, running, data_req} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stopped c=%0d got %b expected 0000", c, {sample, epoch, running, data_req});
      end
    end
    start_gen(10'b0011011111, 32'd0, 32'h8000_0000, 32'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++;
        $display("FAIL restart n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
      end
      samp_log[m_n] = sample;
      model_advance();
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (samp_log[i] !== prefix[9 - i/2]) begin
        n_fail++;
        $display("FAIL restart_prefix cycle=%0d got %b expected %b", i, samp_log[i], prefix[9 - i/2]);
      end
    end
    $display("test_stop_restart: done");
  endtask

  task automatic test_async_reset();
    logic [3:0] e;
    int         lf = 0;
    start_gen(10'($urandom_range(1023, 1)), $urandom, $urandom_range(32'hFFFF_FFFF, 32'h4000_0000), $urandom);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      model_expect(e);
      n_checks++;
      if ({sample, epoch, running, data_req} !== e) begin
        n_fail++; lf++;
        $display("FAIL async_pre n=%0d got %b expected %b", m_n, {sample, epoch, running, data_req}, e);
        if (lf >= 10) break;
      end
      model_advance();
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({sample, epoch, running, data_req} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_rst got %b expected 0001", {sample, epoch, running, data_req});
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sample, epoch, running, data_req} !== 4'b0001) begin
        n_fail++;
        $display("FAIL async_idle c=%0d got %b expected 0001", c, {sample, epoch, running, data_req});
      end
    end
    $display("test_async_reset: done");
  endtask

  task automatic test_random();
    logic [3:0] e;
    for (int t = 0; t < 2; t++) begin
      int lf = 0;
      start_gen(10'($urandom), $urandom, $urandom_range(32'hFFFF_FFFF, 32'h1000_0000), $urandom);
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        model_expect(e);
        n_checks++;
        if ({sample, epoch, running, data_req} !== e) begin
          n_fail++; lf++;
          $display("FAIL random%0d n=%0d got %b expected %b", t, m_n, {sample, epoch, running, data_req}, e);
          if (lf >= 10) break;
        end
        model_advance();
      end
      $display("test_random[%0d]: lo_rate=%h cg_rate=%h word=%h", t, m_lo_rate, m_cg_rate, m_word);
    end
  endtask

  initial begin
    rst   = 1'b1;
    wrReg = 1'b0;
    op    = '0;
    tos   = '0;
    test_reset();
    test_prn1();
    test_carrier();
    test_data();
    test_race();
    test_stop_restart();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gps_sig_gen.md
# gps_sig_gen

Synthetic GPS L1 C/A signal generator: the transmit-side counterpart of the GPS channel correlator. It produces the 1-bit sign `sample` stream a channel consumes, built from a programmable C/A code, code NCO, carrier NCO and 50 bps nav data. It sits beside the GPS channels for loopback self-test and tracking-loop verification, and is programmed through the same CPU register-write bus (`wrReg`/`op`/`tos`).

## Interface
Parameters:
- `CODELEN`, 1023: chips per code epoch.
- `EPOCHS_PER_BIT`, 20: code epochs per nav data bit.

Ports:
- `clk`  in  1  sample clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wrReg`  in  1  CPU register-write strobe.
- `op`  in  16  one-hot register select. Bits used: `SET_GEN_SAT`, `SET_GEN_LO`, `SET_GEN_CG`, `SET_GEN_DATA`, `SET_GEN_CTRL`.
- `tos`  in  32  write data.
- `sample`  out  1  generated sign sample, registered.
- `epoch`  out  1  one-cycle pulse on chip 0 of each code period.
- `data_req`  out  1  level: nav data word is exhausted and needs a reload.
- `running`  out  1  generator is in the RUN state.

## Operation
- Register writes (all apply when `wrReg` and the op bit are set):
  - `SET_GEN_SAT`: `g2_init[10:1] <= tos[9:0]`.
  - `SET_GEN_LO`: `lo_rate <= tos`.
  - `SET_GEN_CG`: `cg_rate <= tos`.
  - `SET_GEN_DATA`: `data_word <= tos`, `bit_idx <= 0`, `data_req <= 0`.
  - `SET_GEN_CTRL`: `tos[0]` is start (1) or stop (0).
- Rate writes take effect on the next cycle, including while running. They do not reset phase.
- FSM has two states, IDLE and RUN.
  - IDLE→RUN on a start write. On entry: `lo_phase = 0`, `cg_phase = 0`, G1 = all ones, G2 = `g2_init`, `chip_idx = 0`, `epoch_cnt = 0`.
  - RUN→IDLE on a stop write. In IDLE: `sample = 0`, `epoch = 0`, NCOs frozen.
  - A start write while already in RUN restarts (re-initialises as above).
- NCOs:
  - 32-bit accumulators: `lo_phase += lo_rate` every cycle, `cg_phase += cg_rate` every cycle. Both wrap modulo 2^32.
  - `chip_adv` = carry out of the `cg_phase` add.
- C/A code:
  - G1 polynomial 1+x^3+x^10. G2 polynomial 1+x^2+x^3+x^6+x^8+x^9+x^10.
  - Shift direction: stage n→n+1, feedback into stage 1, output from stage 10.
  - `chip = G1[10] ^ G2[10]`. Both registers shift on `chip_adv`.
  - On `chip_adv` with `chip_idx == CODELEN-1`: `chip_idx <= 0`, G1 reloaded to all ones, G2 reloaded to `g2_init` (no shift), `epoch_cnt` advances. Otherwise `chip_idx` increments.
- Nav data:
  - `dbit = data_word[31 - bit_idx]`.
  - When `epoch_cnt` wraps from `EPOCHS_PER_BIT-1` to 0, `bit_idx` increments.
  - After bit 31 completes, `data_req <= 1` and `dbit` is forced to 0 until the next `SET_GEN_DATA`.
  - A `SET_GEN_DATA` landing in the same cycle as a bit advance wins: `bit_idx = 0`.
- Output: `sample <= lo_phase[31] ^ chip ^ dbit`. The carrier is a square wave.

## Timing
- Reset values:
  - `sample`, `epoch`, `running`: 0. `data_req`: 1.
  - State is IDLE. All rates, `g2_init` and `data_word` are 0.
- `running` is high from the cycle after the start write.
- First `sample` (chip 0, phase 0) is valid on that same cycle. Latency from NCO state to `sample` is 1 cycle.
- `epoch` is high in the cycle where `sample` carries chip 0 of a period, including the first period after start.
- Asynchronous `rst` mid-RUN forces all outputs to their reset values immediately. The block stays in IDLE until a new start write.
- `cg_rate = 0` holds the current chip indefinitely. No epochs occur.

## Structure
- The shared GPS package holds:
  - op bit indices `SET_GEN_SAT`, `SET_GEN_LO`, `SET_GEN_CG`, `SET_GEN_DATA`, `SET_GEN_CTRL`, allocated alongside the existing channel op bits;
  - `L1_CODELEN`;
  - the G1/G2 tap constants.
- One sub-module, `ca_gen_lfsr`, contains the G1/G2 pair. It has `load`, `adv` and `g2_init` inputs and a `chip` output.
- The NCOs, FSM and data logic stay in the top level.

## Test plan
- **PRN 1 code.** `g2_init = 10'b0011011111`, `cg_rate = 0x80000000`, `lo_rate = 0`, data 0, start → first 10 chips 1100100000 (octal 1440), each held for 2 cycles; `epoch` pulses every 2046 cycles.
- **Carrier.** `lo_rate = 0x40000000`, `cg_rate = 0` (chip fixed) → `sample` toggles with period 4 cycles (2 high, 2 low), XORed with the constant chip.
- **Data bits.** `data_word = 0x80000000`, `cg_rate = 0x80000000` → sample inverted relative to the data-0 run for the first 20 epochs (40920 cycles) only. `data_req` rises after 32×20 epochs.
- **Data reload race.** `SET_GEN_DATA` issued in the cycle of a bit advance → `bit_idx = 0` and `data_req = 0` afterwards; no bit is skipped.
- **Stop/restart.** Stop mid-code → `running = 0` and `sample = 0` next cycle. Start again → chip sequence restarts from the 1440 prefix with `epoch` on the first sample.
- **Asynchronous reset.** Assert `rst` between clock edges mid-RUN → outputs at reset values before the next edge; `data_req = 1`.
